sl_rx_controller: RTL
=====================

# sl_rx_controller

Clocked controller that sequences one asynchronous two-wire SL receiver (sl0/sl1 negative-pulse receiver with 8/16/32-bit modes and parity) and hands its words to the APB side. It does four things:
- Resets and configures the receiver.
- Synchronises its `ready`/`valid` flags and captures completed words into a small FIFO.
- Counts good and bad words.
- Recovers a stalled receiver with a watchdog.

It sits between the receiver and the APB register block of the bridge.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: word FIFO entries, power of two, ≥2.
- `TIMEOUT_CYCLES`, default 4096: clk cycles without line activity mid-word before the watchdog fires.
- `RST_CYCLES`, default 2: cycles `rx_reset_n` is held low per receiver reset.

Ports:
- `clk` input 1: system/APB clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `cfg_enable` input 1: channel enable.
- `cfg_mode` input 2: requested word length (0=8, 1=16, 2=32, 3=reserved).
- `clear_status` input 1: one-cycle pulse; clears counters and sticky flags.
- `sl0`, `sl1` input 1 each: raw line copies, activity monitoring only.
- `rx_data` input 32: receiver data.
- `rx_valid` input 1: receiver valid.
- `rx_ready` input 1: receiver ready.
- `rx_reset_n` output 1: receiver reset, active-low.
- `rx_mode` output 2: receiver mode.
- `word_data` output 32: FIFO head, right-justified.
- `word_valid` output 1: FIFO non-empty.
- `word_ready` input 1: pop.
- `word_cnt` output 16: accepted words, saturating.
- `err_cnt` output 8: parity/length-error words, saturating.
- `overflow` output 1: sticky, word dropped on full FIFO.
- `timeout` output 1: sticky, watchdog fired.

## Operation
- All async inputs (`sl0`, `sl1`, `rx_ready`, `rx_valid`) pass through 2-flop synchronisers.
- `rx_data` is sampled only when synchronised `rx_ready` rises. It is stable then: it changes only on the next bit edge.
- FSM states:
  - **DISABLED**: `rx_reset_n`=0. Entered when `cfg_enable`=0 or `cfg_mode`=3. Leaves to RST_RX when enabled with a legal mode.
  - **RST_RX**: `rx_reset_n`=0 for `RST_CYCLES`. `rx_mode` is loaded from `cfg_mode` on entry. Then goes to IDLE.
  - **IDLE**: armed. A synchronised falling edge on `sl0` or `sl1` moves to RECV. A `cfg_mode` differing from `rx_mode` moves to RST_RX. Disable moves to DISABLED.
  - **RECV**: the watchdog counts clk cycles and reloads to 0 on every synchronised sl falling edge.
    - Watchdog reaches `TIMEOUT_CYCLES`: set `timeout`, go to RST_RX.
    - Rising edge of synchronised `rx_ready`: go to CAPTURE.
    - Mode change or disable: deferred until the word completes or times out.
  - **CAPTURE**, one cycle, then IDLE:
    - Sync `rx_valid`=1: shift the word right by 24/16/0 (mode 0/1/2) and push it. `word_cnt`++.
    - Sync `rx_valid`=0: `err_cnt`++ and nothing is pushed.
- FIFO behaviour:
  - Push on full with no simultaneous pop: the word is dropped and `overflow` is set. `word_cnt` is still incremented.
  - Push and pop in the same cycle on full: both are accepted.
  - Pop on empty: ignored.
- Counters saturate at all-ones.
- `clear_status` has priority over any same-cycle increment or sticky set; that event is lost. It does not touch the FIFO or the FSM.
- Deasserting `cfg_enable` flushes the FIFO.

## Timing
- Reset values:
  - `rx_reset_n`=0, `rx_mode`=0.
  - `word_data`=0, `word_valid`=0.
  - `word_cnt`=0, `err_cnt`=0.
  - `overflow`=0, `timeout`=0.
  - FSM in DISABLED.
- Capture latency: `rx_ready` is first sampled high at edge 1. The FIFO is written at edge 3, and `word_valid` is high after edge 3 when the FIFO was empty.
- `word_data` is registered; a pop at edge n presents the next entry after edge n.
- Line requirement: SL bit period and stop pulse ≥ 4 clk cycles each. Shorter pulses are unsupported.
- A reset mid-word discards the partial word. No counter changes except `timeout` when the watchdog was the cause.
- Timeout of 0 cycles is illegal; parameter assertion.

## Structure
- `sl_pkg`:
  - `sl_mode_e` (MODE_8, MODE_16, MODE_32, MODE_RSVD).
  - `sl_ctrl_state_e`.
  - Function `sl_word_bits(mode)` returning the word length.
  - Function `sl_shift(mode)` returning the alignment shift.
- Sub-module `sl_rx_fifo`: synchronous FIFO, `FIFO_DEPTH` × 32, push/pop/full/empty/flush.
- The FSM, synchronisers, watchdog and counters stay in `sl_rx_controller`.

## Test plan
- Reset, enable, mode 0, send 8-bit word 0xA5 with good parity: `rx_reset_n` high after 2 cycles, `word_data`=0x000000A5, `word_cnt`=1, `err_cnt`=0.
- Mode 1 word whose stop is preceded by only 10 bits (`rx_valid`=0 at stop): nothing pushed, `err_cnt`=1, `word_valid` stays 0.
- Five 32-bit words, `word_ready`=0, depth 4: `overflow`=1, `word_cnt`=5. Popping 4 times yields the first four words in order.
- Three bits sent, then lines idle-high for `TIMEOUT_CYCLES`+10: `timeout`=1, `rx_reset_n` pulsed low 2 cycles, FSM back in IDLE. The next full word is received correctly.
- `cfg_mode` changed 1→2 mid-word: the current word completes in mode 1, then RST_RX, `rx_mode`=2.
- `clear_status` in the same cycle as CAPTURE of a good word: `word_cnt`=0 afterwards, `overflow`=0, `timeout`=0, FIFO contents untouched.

Source files
------------

// File: rtl/sl_pkg.sv
// sl_pkg: shared types and word-length helpers for the SL receive controller.
package sl_pkg;

   typedef enum logic [1:0] {MODE_8, MODE_16, MODE_32, MODE_RSVD} sl_mode_e;

   typedef enum logic [2:0] {
      S_DISABLED,
      S_RST_RX,
      S_IDLE,
      S_RECV,
      S_CAPTURE
   } sl_ctrl_state_e;

   function automatic logic [5:0] sl_word_bits(input sl_mode_e mode);
      return mode == MODE_8  ? 6'd8  :
             mode == MODE_16 ? 6'd16 :
             mode == MODE_32 ? 6'd32 : 6'd0;
   endfunction

   // Receiver words arrive left-justified; this is the right shift that aligns them.
   function automatic logic [5:0] sl_shift(input sl_mode_e mode);
      return mode == MODE_RSVD ? 6'd0 : 6'd32 - sl_word_bits(mode);
   endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// sl_rx_fifo: synchronous word FIFO with flush; head is zero while empty.
module sl_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_push;
   logic         w_pop;

   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/sl_rx_controller.sv
// sl_rx_controller: sequences the async SL receiver, captures its words into a
// FIFO, keeps good/bad word counts and recovers a stalled receiver by watchdog.
module sl_rx_controller import sl_pkg::*; #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int RST_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_enable,
   input  logic [1:0]  cfg_mode,
   input  logic        clear_status,
   input  logic        sl0,
   input  logic        sl1,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_reset_n,
   output logic [1:0]  rx_mode,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [15:0] word_cnt,
   output logic [7:0]  err_cnt,
   output logic        overflow,
   output logic        timeout
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W = $clog2(RST_CYCLES + 1);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end
   if (RST_CYCLES < 1) begin : g_bad_rst
      $error("RST_CYCLES must be at least 1");
   end

   sl_ctrl_state_e  r_state;
   sl_ctrl_state_e  w_next;
   logic [3:0]      r_sync1;
   logic [3:0]      r_sync2;
   logic [1:0]      r_sl_d;
   logic            r_rdy_d;
   logic [WD_W-1:0] r_wdog;
   logic [RC_W-1:0] r_rst_cnt;
   logic [1:0]      r_mode;
   logic            r_rx_reset_n;
   logic [15:0]     r_word_cnt;
   logic [7:0]      r_err_cnt;
   logic            r_overflow;
   logic            r_timeout;
   logic            w_sl_fall;
   logic            w_rdy_rise;
   logic            w_valid;
   logic            w_cfg_ok;
   logic            w_rst_done;
   logic            w_wd_fire;
   logic            w_capture;
   logic            w_wd_evt;
   logic            w_push;
   logic            w_full;
   logic            w_empty;
   logic [31:0]     w_word;

   // Sync order {rx_valid, rx_ready, sl1, sl0}; lines idle high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 4'b0011;
         r_sync2 <= 4'b0011;
         r_sl_d  <= 2'b11;
         r_rdy_d <= 1'b0;
      end else begin
         r_sync1 <= {rx_valid, rx_ready, sl1, sl0};
         r_sync2 <= r_sync1;
         r_sl_d  <= r_sync2[1:0];
         r_rdy_d <= r_sync2[2];
      end
   end

   assign w_sl_fall  = |(r_sl_d & ~r_sync2[1:0]);
   assign w_rdy_rise = r_sync2[2] & ~r_rdy_d;
   assign w_valid    = r_sync2[3];
   assign w_cfg_ok   = cfg_enable && (cfg_mode != MODE_RSVD);
   assign w_rst_done = r_rst_cnt == RC_W'(RST_CYCLES - 1);
   assign w_wd_fire  = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) && !w_sl_fall;

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_wd_evt  = 1'b0;
      case (r_state)
         S_DISABLED: w_next = w_cfg_ok ? S_RST_RX : S_DISABLED;
         S_RST_RX:   w_next = !w_cfg_ok ? S_DISABLED : w_rst_done ? S_IDLE : S_RST_RX;
         S_IDLE:     w_next = !w_cfg_ok ? S_DISABLED :
                              (cfg_mode != r_mode) ? S_RST_RX :
                              w_sl_fall ? S_RECV : S_IDLE;
         // Mode changes and disable wait until the word ends or times out.
         S_RECV: begin
            w_capture = w_rdy_rise;
            w_wd_evt  = !w_rdy_rise && w_wd_fire;
            w_next    = w_rdy_rise ? S_CAPTURE : w_wd_fire ? S_RST_RX : S_RECV;
         end
         S_CAPTURE:  w_next = S_IDLE;
         default:    w_next = S_DISABLED;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_DISABLED;
         r_rst_cnt    <= '0;
         r_mode       <= 2'd0;
         r_rx_reset_n <= 1'b0;
         r_wdog       <= '0;
      end else begin
         r_state      <= w_next;
         r_rst_cnt    <= (r_state == S_RST_RX && w_next == S_RST_RX) ? r_rst_cnt + 1'b1 : '0;
         r_mode       <= (w_next == S_RST_RX && r_state != S_RST_RX) ? cfg_mode : r_mode;
         r_rx_reset_n <= !(w_next == S_DISABLED || w_next == S_RST_RX);
         r_wdog       <= (r_state == S_RECV && w_next == S_RECV && !w_sl_fall) ? r_wdog + 1'b1 : '0;
      end
   end

   // The word is pushed on the edge that detects the ready rise; CAPTURE follows.
   assign w_push = w_capture && w_valid;
   assign w_word = rx_data >> sl_shift(sl_mode_e'(r_mode));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else if (clear_status) begin
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_push && r_word_cnt != '1) r_word_cnt <= r_word_cnt + 1'b1;
         if (w_capture && !w_valid && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
         if (w_push && w_full && !word_ready) r_overflow <= 1'b1;
         if (w_wd_evt) r_timeout <= 1'b1;
      end
   end

   sl_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (!cfg_enable),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (word_ready),
      .o_data  (word_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign word_valid = !w_empty;
   assign rx_reset_n = r_rx_reset_n;
   assign rx_mode    = r_mode;
   assign word_cnt   = r_word_cnt;
   assign err_cnt    = r_err_cnt;
   assign overflow   = r_overflow;
   assign timeout    = r_timeout;

endmodule
